// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional encode chain: frame FSM states,
// encoder memory order and a counter width helper.
package conv_pkg;

    localparam int unsigned MEM_LEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DATA,
        TAIL,
        GAP
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the rom -> encode -> parallel2serial chain: walks ROM
// addresses, qualifies bits into the encoder, appends flush tail and idle gap.
module conv_frame_ctrl #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned MEM_LEN = conv_pkg::MEM_LEN,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic              clk_sig,
    input  logic              reset_sig,
    input  logic              start_sig,
    input  logic [ADDR_W-1:0] base_addr_sig,
    input  logic [ADDR_W-1:0] frame_len_sig,
    input  logic              ready_sig,
    output logic [ADDR_W-1:0] address_sig,
    output logic              rom_en_sig,
    output logic              bit_valid_sig,
    output logic              tail_sig,
    output logic              enc_clr_sig,
    output logic              busy_sig,
    output logic              done_sig,
    output logic              err_sig
);
    import conv_pkg::*;

    localparam int unsigned IW = ADDR_W + 1;
    localparam int unsigned TW = cnt_w(MEM_LEN);
    localparam int unsigned GW = cnt_w(GAP_CYC);
    // done is registered and lands in the first IDLE cycle, which itself
    // counts as the last gap cycle; GAP state therefore lasts GAP_CYC-1 cycles.
    localparam int unsigned GAP_LAST = (GAP_CYC > 1) ? GAP_CYC - 2 : 0;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tcnt;
    logic [GW-1:0]     gcnt;
    logic              done_q;
    logic              last_data;
    logic              last_tail;
    logic              last_gap;

    assign last_data = (idx == IW'(len_q) - IW'(1));
    assign last_tail = (tcnt == TW'(MEM_LEN - 1));
    assign last_gap  = (gcnt == GW'(GAP_LAST));

    always_comb begin
        state_n       = state;
        address_sig   = '0;
        rom_en_sig    = 1'b0;
        bit_valid_sig = 1'b0;
        tail_sig      = 1'b0;
        enc_clr_sig   = 1'b0;
        err_sig       = 1'b0;
        case (state)
            IDLE: begin
                if (start_sig) begin
                    if (frame_len_sig == '0) err_sig = 1'b1;
                    else                     state_n = CLEAR;
                end
            end
            CLEAR: begin
                enc_clr_sig = 1'b1;
                rom_en_sig  = 1'b1;
                address_sig = base_q;
                state_n     = DATA;
            end
            DATA: begin
                bit_valid_sig = 1'b1;
                rom_en_sig    = 1'b1;
                // look-ahead address so the sync ROM has the next bit ready
                address_sig   = base_q + idx[ADDR_W-1:0] + ADDR_W'(ready_sig);
                if (ready_sig && last_data) state_n = TAIL;
            end
            TAIL: begin
                bit_valid_sig = 1'b1;
                tail_sig      = 1'b1;
                address_sig   = base_q + idx[ADDR_W-1:0];
                if (ready_sig && last_tail) state_n = (GAP_CYC > 1) ? GAP : IDLE;
            end
            GAP: begin
                if (last_gap) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            state  <= IDLE;
            base_q <= '0;
            len_q  <= '0;
            idx    <= '0;
            tcnt   <= '0;
            gcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= (state_n == IDLE) && (state == TAIL || state == GAP);
            case (state)
                IDLE: begin
                    if (start_sig && frame_len_sig != '0) begin
                        base_q <= base_addr_sig;
                        len_q  <= frame_len_sig;
                        idx    <= '0;
                    end
                end
                DATA: begin
                    tcnt <= '0;
                    if (ready_sig) idx <= idx + IW'(1);
                end
                TAIL: begin
                    gcnt <= '0;
                    if (ready_sig) tcnt <= tcnt + TW'(1);
                end
                GAP: gcnt <= gcnt + GW'(1);
                default: ;
            endcase
        end
    end

    assign busy_sig = (state != IDLE);
    assign done_sig = done_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with a sync ROM stand-in and a
// frame-level reference model checked every cycle.
module tb_conv_frame_ctrl;

    localparam int unsigned AW = 11;
    localparam int ML = 2;
    localparam int GC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic          ready;
    logic [AW-1:0] address;
    logic          rom_en, valid, tail, clr, busy, done, err;

    always #5 clk = ~clk;

    conv_frame_ctrl #(.ADDR_W(AW), .MEM_LEN(ML), .GAP_CYC(GC)) dut (
        .clk_sig(clk), .reset_sig(reset), .start_sig(start),
        .base_addr_sig(base), .frame_len_sig(len), .ready_sig(ready),
        .address_sig(address), .rom_en_sig(rom_en), .bit_valid_sig(valid),
        .tail_sig(tail), .enc_clr_sig(clr), .busy_sig(busy),
        .done_sig(done), .err_sig(err)
    );

    function automatic logic rom_f(input logic [AW-1:0] a);
        logic [AW-1:0] h;
        h = a ^ (a >> 3) ^ 11'h2B5;
        return ^(h & 11'h4D3);
    endfunction

    logic rom_q;
    logic enc_in;
    always_ff @(posedge clk) if (rom_en) rom_q <= rom_f(address);
    assign enc_in = tail ? 1'b0 : rom_q;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: frame position as accepts so far and gap cycles elapsed
    logic          m_act = 1'b0, m_clr = 1'b0;
    int            m_k = 0, m_g = 0, m_len = 0;
    logic [AW-1:0] m_base = '0;

    int clr_cyc[$], done_cyc[$];
    logic [AW-1:0] addr_log[$];
    int first_valid, valid_cnt, data_acc, tail_acc, err_cnt, busy_cnt;

    always @(negedge clk) begin
        logic frame_end, idle_like;
        logic e_busy, e_done, e_err, e_clr, e_valid, e_tail, e_rom;
        logic [AW-1:0] e_addr;
        if (reset) begin
            m_act = 1'b0;
            m_clr = 1'b0;
        end else begin
            frame_end = m_act && !m_clr && (m_k == m_len + ML) && (m_g == GC - 1);
            idle_like = !m_act || frame_end;
            e_busy  = m_act && !frame_end;
            e_done  = frame_end;
            e_err   = idle_like && start && (len == 0);
            e_clr   = m_act && m_clr;
            e_valid = m_act && !m_clr && (m_k < m_len + ML);
            e_tail  = e_valid && (m_k >= m_len);
            e_rom   = e_clr || (e_valid && !e_tail);
            if (e_clr)                  e_addr = m_base;
            else if (e_valid && !e_tail) e_addr = AW'(int'(m_base) + m_k + int'(ready));
            else if (e_tail)            e_addr = AW'(int'(m_base) + m_len);
            else                        e_addr = '0;
            chk("cycle_outputs",
                32'({busy, done, err, clr, valid, tail, rom_en, address}),
                32'({e_busy, e_done, e_err, e_clr, e_valid, e_tail, e_rom, e_addr}));
            if (e_valid && ready && !e_tail) begin
                chk("rom_bit", 32'(enc_in), 32'(rom_f(AW'(int'(m_base) + m_k))));
                data_acc++;
            end
            if (e_tail && ready) tail_acc++;
            if (clr)  clr_cyc.push_back(cyc);
            if (done) done_cyc.push_back(cyc);
            if (rom_en) addr_log.push_back(address);
            if (valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (err)  err_cnt++;
            if (busy) busy_cnt++;
            if (idle_like) begin
                if (start && len != 0) begin
                    m_act = 1'b1; m_clr = 1'b1; m_k = 0; m_g = 0;
                    m_base = base; m_len = int'(len);
                end else begin
                    m_act = 1'b0;
                end
            end else if (m_clr)              m_clr = 1'b0;
            else if (m_k < m_len + ML) begin if (ready) m_k++; end
            else                             m_g++;
        end
    end

    logic toggle_ready = 1'b0;
    int   s;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (toggle_ready) ready = ~ready;
        end
    endtask

    task automatic clear_logs();
        clr_cyc.delete(); done_cyc.delete(); addr_log.delete();
        first_valid = -1; valid_cnt = 0; data_acc = 0; tail_acc = 0;
        err_cnt = 0; busy_cnt = 0;
    endtask

    task automatic kick(input int b, input int l, input logic hold);
        base  = AW'(b);
        len   = AW'(l);
        start = 1'b1;
        s     = cyc;
        tick(1);
        if (!hold) start = 1'b0;
    endtask

    task automatic run_until_dones(input int n, input int budget);
        int c = 0;
        while (done_cyc.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        if (done_cyc.size() < n) chk("done_timeout", 32'(done_cyc.size()), 32'(n));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base = '0; len = '0; ready = 1'b1;
        clear_logs();
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", 32'(address), 32'd0);
        tick(1);

        // 1: base 0, len 4, ready held high
        clear_logs();
        kick(0, 4, 1'b0);
        run_until_dones(1, 40);
        chk("t1_clr_cycle", 32'(clr_cyc[0] - s), 32'd1);
        chk("t1_first_valid", 32'(first_valid - s), 32'd2);
        chk("t1_valid_cycles", 32'(valid_cnt), 32'd6);
        chk("t1_done_cycle", 32'(done_cyc[0] - s), 32'd11);
        chk("t1_addr_count", 32'(addr_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("t1_addr", 32'(addr_log[i]), 32'(i));
        tick(2);

        // 2: address wrap at the top of the ROM
        clear_logs();
        kick(2046, 4, 1'b0);
        run_until_dones(1, 40);
        chk("t2_addr0", 32'(addr_log[0]), 32'd2046);
        chk("t2_addr1", 32'(addr_log[1]), 32'd2047);
        chk("t2_addr2", 32'(addr_log[2]), 32'd0);
        chk("t2_addr3", 32'(addr_log[3]), 32'd1);
        chk("t2_data_acc", 32'(data_acc), 32'd4);
        tick(2);

        // 3: ready toggling every cycle
        clear_logs();
        toggle_ready = 1'b1;
        kick(300, 3, 1'b0);
        run_until_dones(1, 60);
        toggle_ready = 1'b0;
        ready = 1'b1;
        chk("t3_data_acc", 32'(data_acc), 32'd3);
        chk("t3_tail_acc", 32'(tail_acc), 32'd2);
        tick(2);

        // 4: zero-length start, then a start during DATA
        clear_logs();
        kick(77, 0, 1'b0);
        tick(4);
        chk("t4_err_pulses", 32'(err_cnt), 32'd1);
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("t4_rom_en", 32'(addr_log.size()), 32'd0);
        clear_logs();
        kick(100, 5, 1'b0);
        tick(3);
        base = AW'(500); len = AW'(2); start = 1'b1;
        tick(1);
        start = 1'b0;
        run_until_dones(1, 40);
        chk("t4_done_cycle", 32'(done_cyc[0] - s), 32'd12);
        chk("t4_addr0", 32'(addr_log[0]), 32'd100);
        chk("t4_data_acc", 32'(data_acc), 32'd5);
        chk("t4_clr_count", 32'(clr_cyc.size()), 32'd1);
        tick(2);

        // 5: reset mid-DATA, then a fresh frame
        clear_logs();
        kick(10, 8, 1'b0);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_reset", 32'(busy), 32'd0);
        chk("t5_valid_after_reset", 32'(valid), 32'd0);
        tick(1);
        clear_logs();
        kick(10, 8, 1'b0);
        run_until_dones(1, 40);
        chk("t5_data_acc", 32'(data_acc), 32'd8);
        chk("t5_done_cycle", 32'(done_cyc[0] - s), 32'd15);
        tick(2);

        // 6: start held high gives back-to-back frames
        clear_logs();
        kick(20, 2, 1'b1);
        run_until_dones(2, 60);
        start = 1'b0;
        run_until_dones(3, 40);
        chk("t6_b2b_first", 32'(clr_cyc[1] - done_cyc[0]), 32'd1);
        chk("t6_b2b_second", 32'(clr_cyc[2] - done_cyc[1]), 32'd1);
        chk("t6_done_cycle", 32'(done_cyc[0] - s), 32'd9);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
